// File: rtl/aes_block_uart_tx.sv
// ----------------------------------------------------------------------------
// aes_block_uart_tx
//
// Serialises one 128-bit encrypted block onto a UART transmit line as sixteen
// 8N1 characters. The most significant byte (encoded_data[127:120]) goes out
// first, and each byte is sent LSB first. The stop bit of one byte runs
// straight into the start bit of the next, with no extra gap.
//
// A frame starts on a rising edge of encoded_state. The level itself is
// ignored, so an upstream stage that holds "block ready" high for a long time
// produces exactly one frame. Rising edges that arrive while a frame is in
// flight are dropped, not queued.
//
// Parameters
//   CLOCK_PER_BIT  clock cycles per UART bit (2..65535)
//
// Ports
//   clk            system clock, rising-edge active
//   rst            synchronous active-high reset
//   encoded_data   128-bit block, sampled only on the capture edge
//   encoded_state  "block ready" level from the encryption stage
//   tx             UART serial line (idles high), registered
//   busy           high while a 16-byte frame is in progress, registered
//   done           one-cycle pulse at the end of the 16th stop bit, registered
// ----------------------------------------------------------------------------
module aes_block_uart_tx #(
    parameter int CLOCK_PER_BIT = 10417
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] encoded_data,
    input  logic         encoded_state,
    output logic         tx,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Last count value of a bit period.
    localparam logic [15:0] BAUD_LAST = 16'(CLOCK_PER_BIT - 1);

    state_t         state_reg;
    logic           prev_reg;
    logic [127:0]   shift_reg;
    logic [3:0]     byte_idx_reg;
    logic [2:0]     bit_idx_reg;
    logic [15:0]    baud_cnt_reg;
    logic           tx_reg;
    logic           busy_reg;
    logic           done_reg;

    logic           request;
    logic           baud_end;
    logic [7:0]     cur_byte;
    logic [2:0]     next_bit_idx;
    logic           next_data_bit;

    // Rising edge of the ready level. prev_reg resets to 1, so a level that is
    // already high when reset releases is not mistaken for a fresh request.
    assign request  = encoded_state & ~prev_reg;
    assign baud_end = (baud_cnt_reg == BAUD_LAST);

    // The byte being sent always sits in the top eight bits of the shift
    // register. The register moves left by a byte after each stop bit.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_cur_byte
            assign cur_byte[gi] = shift_reg[120 + gi];
        end
    endgenerate

    // The next data bit is loaded into tx on the edge that ends the current
    // bit. That keeps tx a plain register with no output mux after it.
    assign next_bit_idx  = bit_idx_reg + 3'd1;
    assign next_data_bit = cur_byte[next_bit_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            prev_reg     <= 1'b1;
            shift_reg    <= '0;
            byte_idx_reg <= '0;
            bit_idx_reg  <= '0;
            baud_cnt_reg <= '0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            prev_reg <= encoded_state;
            done_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    tx_reg       <= 1'b1;
                    busy_reg     <= 1'b0;
                    baud_cnt_reg <= '0;
                    if (request) begin
                        // The start bit begins on the capture edge itself.
                        shift_reg    <= encoded_data;
                        byte_idx_reg <= '0;
                        bit_idx_reg  <= '0;
                        tx_reg       <= 1'b0;
                        busy_reg     <= 1'b1;
                        state_reg    <= START;
                    end
                end

                START: begin
                    if (baud_end) begin
                        baud_cnt_reg <= '0;
                        bit_idx_reg  <= '0;
                        tx_reg       <= cur_byte[0];
                        state_reg    <= DATA;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 16'd1;
                    end
                end

                DATA: begin
                    if (baud_end) begin
                        baud_cnt_reg <= '0;
                        if (bit_idx_reg == 3'd7) begin
                            tx_reg    <= 1'b1;
                            state_reg <= STOP;
                        end else begin
                            bit_idx_reg <= next_bit_idx;
                            tx_reg      <= next_data_bit;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 16'd1;
                    end
                end

                STOP: begin
                    if (baud_end) begin
                        baud_cnt_reg <= '0;
                        if (byte_idx_reg != 4'd15) begin
                            byte_idx_reg <= byte_idx_reg + 4'd1;
                            shift_reg    <= {shift_reg[119:0], 8'h00};
                            tx_reg       <= 1'b0;
                            state_reg    <= START;
                        end else begin
                            // The last stop bit ends here. done and the fall of
                            // busy share this edge. A request seen on this same
                            // edge is lost, because the FSM is not yet in IDLE.
                            byte_idx_reg <= '0;
                            tx_reg       <= 1'b1;
                            busy_reg     <= 1'b0;
                            done_reg     <= 1'b1;
                            state_reg    <= IDLE;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 16'd1;
                    end
                end

                default: begin
                    tx_reg    <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign tx   = tx_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_aes_block_uart_tx.sv
// ----------------------------------------------------------------------------
// tb_aes_block_uart_tx
//
// Directed scenarios with random block contents for aes_block_uart_tx at
// CLOCK_PER_BIT = 4. The expected tx waveform comes from the frame rules in
// plain arithmetic: each bit period is 4 cycles, each character is 10 periods,
// and a frame is 16 characters. A separate mid-bit line decoder rebuilds the
// bytes and compares them with the block that was sent.
// ----------------------------------------------------------------------------
module tb_aes_block_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 16 * 10 * CPB;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] encoded_data;
    logic         encoded_state;
    logic         tx;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_block_uart_tx #(.CLOCK_PER_BIT(CPB)) dut (
        .clk           (clk),
        .rst           (rst),
        .encoded_data  (encoded_data),
        .encoded_state (encoded_state),
        .tx            (tx),
        .busy          (busy),
        .done          (done)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level k cycles after the capture edge.
    function automatic logic model_tx(input logic [127:0] d, input int k);
        int p;
        int b;
        int pos;
        logic [7:0] byt;
        p   = k / CPB;
        b   = p / 10;
        pos = p % 10;
        byt = d[127 - 8 * b -: 8];
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return byt[pos - 1];
    endfunction

    function automatic logic [127:0] rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Idle line: tx high, not busy, no done pulse, for n cycles.
    task automatic check_idle(input string tag, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        check(tag, 128'(bad), 128'(0));
    endtask

    // The caller must make the capture happen on the next rising edge.
    // mode 0: plain frame.
    // mode 1: a 0->1 edge at cycle 300 carries alt, and must be ignored. A new
    //         edge with chain data is then raised just after done, so the
    //         capture falls on the edge after done.
    // mode 2: reset is asserted after cycle 200.
    task automatic frame(input string tag, input logic [127:0] exp, input int mode,
                         input logic [127:0] alt, input logic [127:0] chain);
        logic samp [FRAME];
        int bad = 0;
        int busy_cnt = 0;
        int done_cnt = 0;
        int frame_bad = 0;
        int last;
        logic [7:0] byt;
        last = (mode == 2) ? 200 : FRAME;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            if (k < FRAME) begin
                samp[k] = tx;
                if (tx !== model_tx(exp, k)) bad++;
                if (busy === 1'b1) busy_cnt++;
                if (done !== 1'b0) done_cnt++;
                if (mode == 1) begin
                    if (k == 290) encoded_state = 1'b0;
                    if (k == 300) begin
                        encoded_state = 1'b1;
                        encoded_data  = alt;
                    end
                    if (k == 600) encoded_state = 1'b0;
                end
            end else begin
                check({tag, "_done"}, 128'(done), 128'(1));
                check({tag, "_busy_fall"}, 128'(busy), 128'(0));
                check({tag, "_tx_end"}, 128'(tx), 128'(1));
                if (mode == 1) begin
                    encoded_state = 1'b1;
                    encoded_data  = chain;
                end
            end
        end

        check({tag, "_tx_wave"}, 128'(bad), 128'(0));
        check({tag, "_done_early"}, 128'(done_cnt), 128'(0));

        if (mode == 2) begin
            check({tag, "_busy_cycles"}, 128'(busy_cnt), 128'(201));
            rst = 1'b1;
            @(negedge clk);
            check({tag, "_rst_out"}, {125'd0, tx, busy, done}, 128'b100);
            rst = 1'b0;
        end else begin
            check({tag, "_busy_cycles"}, 128'(busy_cnt), 128'(FRAME));
            // The decoder samples each bit in the middle of its period.
            for (int b = 0; b < 16; b++) begin
                if (samp[b * 40 + 2] !== 1'b0)  frame_bad++;
                if (samp[b * 40 + 38] !== 1'b1) frame_bad++;
                for (int i = 0; i < 8; i++) byt[i] = samp[b * 40 + (i + 1) * 4 + 2];
                $display("%s byte %0d rx=%02h", tag, b, byt);
                check({tag, "_rx_byte"}, 128'(byt), 128'(exp[127 - 8 * b -: 8]));
            end
            check({tag, "_framing"}, 128'(frame_bad), 128'(0));
        end
    endtask

    initial begin
        logic [127:0] d1;
        logic [127:0] d2;
        logic [127:0] d3;

        rst           = 1'b1;
        encoded_state = 1'b0;
        encoded_data  = '0;

        // 1. Reset values over three reset cycles, then a quiet line.
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_out", {125'd0, tx, busy, done}, 128'b100);
        end
        rst = 1'b0;
        check_idle("idle_after_reset", 100);

        // 2. Basic frame with a known block.
        d1 = 128'h00112233445566778899AABBCCDDEEFF;
        encoded_data  = d1;
        encoded_state = 1'b1;
        frame("basic", d1, 0, '0, '0);
        encoded_state = 1'b0;
        check_idle("idle_after_basic", 20);

        // 3. Level held high for 2000 cycles gives one frame only.
        d1 = rand_block();
        encoded_data  = d1;
        encoded_state = 1'b1;
        frame("held", d1, 0, '0, '0);
        check_idle("held_no_second", 2000 - FRAME - 1);
        encoded_state = 1'b0;
        check_idle("held_release", 5);

        // 4. A request mid-frame is dropped. A request right after done is
        //    taken at once.
        d1 = rand_block();
        d2 = ~d1;
        d3 = rand_block();
        encoded_data  = d1;
        encoded_state = 1'b1;
        frame("busy_req", d1, 1, d2, d3);
        frame("chained", d3, 0, '0, '0);
        encoded_state = 1'b0;
        check_idle("idle_after_chain", 50);

        // 5. Reset mid-frame aborts the frame for good.
        d1 = rand_block();
        encoded_data  = d1;
        encoded_state = 1'b1;
        frame("abort", d1, 2, '0, '0);
        check_idle("abort_quiet", 700);
        encoded_state = 1'b0;

        // 6. Level high across reset release does not send. A fresh edge does.
        rst           = 1'b1;
        encoded_state = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle("high_across_reset", 100);
        encoded_state = 1'b0;
        check_idle("drop_low", 2);
        d1 = rand_block();
        encoded_data  = d1;
        encoded_state = 1'b1;
        frame("after_reset_edge", d1, 0, '0, '0);
        encoded_state = 1'b0;
        check_idle("idle_final", 20);

        // Random blocks separated by random idle gaps.
        for (int r = 0; r < 3; r++) begin
            d1 = rand_block();
            encoded_data  = d1;
            encoded_state = 1'b1;
            frame("random", d1, 0, '0, '0);
            encoded_state = 1'b0;
            encoded_data  = rand_block();
            check_idle("random_gap", 2 + int'($urandom_range(0, 30)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
